lc3_mem_if: RTL and testbench
=============================

Name: lc3_mem_if

Overview:
- Memory-interface stage directly downstream of the LC-3 control FSM.
- Owns the MAR and MDR registers and turns the FSM's one-cycle ldMAR/ldMDR/selMDR/memWE strobes into a req/ack handshake with external memory.
- Drives the FSM's `enable` input low to freeze it while an access is outstanding, so variable-latency memory works without changing the FSM.

Parameters:
- ADDR_W, 16, address width (MAR).
- DATA_W, 16, data width (MDR, bus, memory data).
- TIMEOUT, 255, max cycles an access may wait for mem_ack before the error state; 0 disables the watchdog.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- ldMAR  in  1  load MAR from bus_in.
- ldMDR  in  1  load MDR; source selected by selMDR.
- selMDR  in  1  1 = memory read via handshake; 0 = load bus_in immediately.
- memWE  in  1  write MDR to memory at address MAR.
- bus_in  in  DATA_W  processor bus value (ALU/MARMUX result).
- mar  out  ADDR_W  MAR register.
- mdr  out  DATA_W  MDR register (gated onto the bus by the datapath when enaMDR).
- enable  out  1  to the control FSM; 1 = FSM may advance.
- mem_req  out  1  access request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  ADDR_W  equals mar.
- mem_wdata  out  DATA_W  equals mdr.
- mem_rdata  in  DATA_W  read data; valid when mem_ack in READ.
- mem_ack  in  1  access complete; sampled only while mem_req=1.
- mem_err  out  1  sticky error flag.

Behaviour:
- Reset: state=IDLE, mar=0, mdr=0, counter=0. Outputs after reset: enable=1, mem_req=0, mem_we=0, mem_err=0.
- States: IDLE, READ, WRITE, ERR. Outputs are a function of state only (Moore):
  - enable = (state==IDLE).
  - mem_req = READ|WRITE.
  - mem_we = WRITE.
  - mem_err = ERR.
- Strobes are acted on only in IDLE. Outside IDLE the FSM is frozen and emits all-zero strobes; any nonzero strobe is ignored.
- IDLE:
  - ldMAR: mar <= bus_in.
  - ldMDR & !selMDR: mdr <= bus_in. No stall; stay IDLE.
  - ldMDR & selMDR: -> READ.
  - memWE: -> WRITE.
  - ldMAR together with a read/write strobe: mar loads at the same edge, and the access uses the new mar.
  - ldMDR & selMDR & memWE in the same cycle is a protocol violation: -> ERR, no access issued.
  - ldMDR & !selMDR & memWE: mdr <= bus_in, then WRITE uses the new mdr.
- READ:
  - mem_ack=1: mdr <= mem_rdata, -> IDLE.
  - Otherwise: counter++.
- WRITE:
  - mem_ack=1: -> IDLE.
  - Otherwise: counter++.
- Counter: cleared on entry to READ/WRITE.
  - If TIMEOUT!=0 and counter reaches TIMEOUT without ack: -> ERR.
- ERR: enable=0, mem_req=0. Held until reset.
- Latency:
  - Strobe at edge E puts the block in READ/WRITE for cycle E+1; enable=0 from that cycle.
  - An ack in the first request cycle gives exactly 1 stall cycle, with enable=1 again at E+2.
  - An ack after k waiting cycles gives k+1 stall cycles.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are stable from req rise until the ack cycle inclusive.
  - mem_req deasserts the cycle after ack; there are never back-to-back requests without an IDLE cycle.
  - mem_ack while mem_req=0 is ignored.
- Reset mid-access: outstanding request abandoned, mem_req=0 next cycle, all registers reset.
- Widths: no arithmetic on data. Counter is clog2(TIMEOUT+1) bits and saturates; no wrap.

Decomposition:
- Shared package lc3_pkg:
  - ADDR_W and DATA_W defaults.
  - mem_if state encoding (IDLE=2'd0, READ=2'd1, WRITE=2'd2, ERR=2'd3).
  - These width constants are also used by the control FSM and datapath.
- Sub-module lc3_mem_watchdog: timeout counter with clear/inc/expired.
- The MAR/MDR registers and FSM stay in lc3_mem_if.

Test Plan:
- Reset, then bus_in=16'h3000 with ldMAR=1 -> mar=16'h3000 and mem_addr=16'h3000 next cycle; enable stays 1.
- Read with zero-wait memory: ldMDR=selMDR=1, memory acks in the first req cycle with rdata=16'h1234 -> mem_req high 1 cycle, mem_we=0, enable low exactly 1 cycle, mdr=16'h1234.
- Write with 3-cycle ack delay: mdr<=16'hBEEF via ldMDR/selMDR=0 (enable stays 1), then memWE -> mem_req=mem_we=1 for 4 cycles with mem_wdata=16'hBEEF and addr stable; enable low 4 cycles; returns to IDLE.
- Timeout: TIMEOUT=4, read issued, no ack -> enable low permanently, mem_err=1 after 4 waiting cycles; reset clears everything.
- Reset asserted in the 2nd cycle of a pending read -> mem_req=0 and enable=1 the cycle after reset; mar=mdr=0.
- Protocol violation: ldMDR=selMDR=memWE=1 -> mem_err=1, mem_req never asserts.

Source files
------------

// File: rtl/lc3_pkg.sv
// lc3_pkg: widths and memory-interface state encoding shared across the LC-3 slice.
package lc3_pkg;
    localparam int LC3_ADDR_W = 16;
    localparam int LC3_DATA_W = 16;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        ERR   = 2'd3
    } mem_state_t;
endpackage

// File: rtl/lc3_mem_watchdog.sv
// lc3_mem_watchdog: saturating wait counter; expired flags the wait that reaches TIMEOUT.
module lc3_mem_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (reset || clear) r_cnt <= '0;
        else if (inc && r_cnt != CW'(TIMEOUT)) r_cnt <= r_cnt + 1'b1;
    end
    // Fires on the wait whose increment would make the count equal TIMEOUT.
    assign expired = (TIMEOUT != 0) && inc && (r_cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/lc3_mem_if.sv
// lc3_mem_if: MAR/MDR owner that turns control-FSM strobes into a req/ack memory
// handshake, freezing the FSM via enable while an access is outstanding.
module lc3_mem_if
    import lc3_pkg::*;
#(
    parameter int ADDR_W  = LC3_ADDR_W,
    parameter int DATA_W  = LC3_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ldMAR,
    input  logic              ldMDR,
    input  logic              selMDR,
    input  logic              memWE,
    input  logic [DATA_W-1:0] bus_in,
    output logic [ADDR_W-1:0] mar,
    output logic [DATA_W-1:0] mdr,
    output logic              enable,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_err
);
    mem_state_t        r_state, w_next;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_mdr;
    logic              w_idle, w_busy, w_expired;

    assign w_idle = (r_state == IDLE);
    assign w_busy = (r_state == READ) || (r_state == WRITE);

    lc3_mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (!w_busy),
        .inc     (w_busy && !mem_ack),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        r_state <= reset ? IDLE : w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_idle)
            w_next = (ldMDR && selMDR && memWE) ? ERR :
                     (ldMDR && selMDR)          ? READ :
                     memWE                      ? WRITE : IDLE;
        else if (w_busy)
            w_next = mem_ack ? IDLE : w_expired ? ERR : r_state;
    end

    always_comb begin
        enable    = w_idle;
        mem_req   = w_busy;
        mem_we    = (r_state == WRITE);
        mem_err   = (r_state == ERR);
        mar       = r_mar;
        mdr       = r_mdr;
        mem_addr  = r_mar;
        mem_wdata = r_mdr;
    end

    // A direct MDR load and a write in the same cycle land before the write is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mar <= '0;
            r_mdr <= '0;
        end else begin
            if (w_idle && ldMAR) r_mar <= ADDR_W'(bus_in);
            if (w_idle && ldMDR && !selMDR) r_mdr <= bus_in;
            else if (r_state == READ && mem_ack) r_mdr <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_lc3_mem_if.sv
// tb_lc3_mem_if: directed and randomized checks of lc3_mem_if against a register-level reference model.
module tb_lc3_mem_if;
    logic        clk = 0, reset = 1;
    logic        ldMAR = 0, ldMDR = 0, selMDR = 0, memWE = 0, mem_ack = 0;
    logic [15:0] bus_in = 0, mem_rdata = 0;
    logic [15:0] mar, mdr, mem_addr, mem_wdata;
    logic        enable, mem_req, mem_we, mem_err;
    int          checks = 0, errors = 0;
    logic [15:0] m_mar = 0, m_mdr = 0;

    lc3_mem_if #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .ldMAR(ldMAR), .ldMDR(ldMDR), .selMDR(selMDR),
        .memWE(memWE), .bus_in(bus_in), .mar(mar), .mdr(mdr), .enable(enable),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes;
        {ldMAR, ldMDR, selMDR, memWE} = 4'b0;
    endtask

    task automatic apply_reset;
        clear_strobes();
        mem_ack = 0;
        reset = 1;
        step();
        reset = 0;
        m_mar = 0;
        m_mdr = 0;
    endtask

    // Memory responder: acks after `delay` waiting cycles, measures stall length and
    // whether the request outputs held steady; comparisons are made by the callers.
    task automatic run_access(input int delay, input logic [15:0] rdata, input bit noise,
                              output int stalls, output bit stable,
                              output logic [15:0] a0, output logic [15:0] wd0, output logic we0);
        step();
        clear_strobes();
        stalls = 0;
        stable = 1;
        a0 = mem_addr;
        wd0 = mem_wdata;
        we0 = mem_we;
        for (int i = 0; i < 40 && !enable; i++) begin
            stalls++;
            if (!mem_req || mem_we !== we0 || mem_addr !== a0 || mem_wdata !== wd0 || mem_err)
                stable = 0;
            mem_ack = (stalls == delay + 1);
            mem_rdata = mem_ack ? rdata : 16'($urandom);
            if (noise) begin
                {ldMAR, ldMDR, selMDR, memWE} = 4'($urandom);
                bus_in = 16'($urandom);
            end
            step();
        end
        mem_ack = 0;
        clear_strobes();
    endtask

    task automatic test_reset;
        checks++;
        if (enable !== 1 || mem_req !== 0 || mem_we !== 0 || mem_err !== 0 || mar !== 0 || mdr !== 0) begin
            errors++;
            $display("FAIL reset: en=%b req=%b we=%b err=%b mar=%h mdr=%h, want 1 0 0 0 0000 0000",
                     enable, mem_req, mem_we, mem_err, mar, mdr);
        end
    endtask

    task automatic test_ldmar;
        bus_in = 16'h3000;
        ldMAR = 1;
        step();
        clear_strobes();
        m_mar = 16'h3000;
        checks++;
        if (mar !== 16'h3000 || mem_addr !== 16'h3000 || enable !== 1) begin
            errors++;
            $display("FAIL ldmar: mar=%h addr=%h en=%b, want 3000 3000 1", mar, mem_addr, enable);
        end
    endtask

    task automatic test_read_zero_wait;
        int st; bit stb; logic [15:0] a, wd; logic we;
        ldMDR = 1; selMDR = 1;
        run_access(0, 16'h1234, 0, st, stb, a, wd, we);
        m_mdr = 16'h1234;
        checks++;
        if (st !== 1 || we !== 0 || !stb) begin
            errors++;
            $display("FAIL read0 handshake: stalls=%0d we=%b stable=%b, want 1 0 1", st, we, stb);
        end
        checks++;
        if (mdr !== 16'h1234 || a !== 16'h3000 || mem_req !== 0) begin
            errors++;
            $display("FAIL read0 data: mdr=%h addr=%h req=%b, want 1234 3000 0", mdr, a, mem_req);
        end
    endtask

    task automatic test_write_delay;
        int st; bit stb; logic [15:0] a, wd; logic we;
        bus_in = 16'hBEEF; ldMDR = 1; selMDR = 0;
        step();
        clear_strobes();
        m_mdr = 16'hBEEF;
        checks++;
        if (mdr !== 16'hBEEF || enable !== 1 || mem_req !== 0) begin
            errors++;
            $display("FAIL mdr_direct: mdr=%h en=%b req=%b, want beef 1 0", mdr, enable, mem_req);
        end
        memWE = 1;
        run_access(3, 16'h0, 0, st, stb, a, wd, we);
        checks++;
        if (st !== 4 || we !== 1 || wd !== 16'hBEEF || a !== 16'h3000 || !stb) begin
            errors++;
            $display("FAIL write3: stalls=%0d we=%b wdata=%h addr=%h stable=%b, want 4 1 beef 3000 1",
                     st, we, wd, a, stb);
        end
        checks++;
        if (enable !== 1 || mem_req !== 0 || mem_err !== 0 || mdr !== 16'hBEEF) begin
            errors++;
            $display("FAIL write3 end: en=%b req=%b err=%b mdr=%h, want 1 0 0 beef", enable, mem_req, mem_err, mdr);
        end
    endtask

    task automatic test_random;
        int st, op, dly; bit stb, ld, wmd; logic [15:0] a, wd, bv, rd; logic we;
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 3);
            ld = 1'($urandom);
            wmd = 1'($urandom);
            bv = 16'($urandom);
            rd = 16'($urandom);
            dly = $urandom_range(0, 3);
            bus_in = bv;
            if (op < 2) begin
                ldMAR = (op == 0) | ld;
                ldMDR = (op == 1);
                mem_ack = 1'($urandom);
                if (ldMAR) m_mar = bv;
                if (ldMDR) m_mdr = bv;
                step();
                clear_strobes();
                mem_ack = 0;
                checks++;
                if (enable !== 1 || mem_req !== 0 || mar !== m_mar || mdr !== m_mdr) begin
                    errors++;
                    $display("FAIL rand_idle[%0d]: en=%b req=%b mar=%h mdr=%h, want 1 0 %h %h",
                             n, enable, mem_req, mar, mdr, m_mar, m_mdr);
                end
            end else begin
                ldMAR = ld;
                if (ld) m_mar = bv;
                if (op == 2) begin
                    ldMDR = 1; selMDR = 1;
                end else begin
                    memWE = 1;
                    ldMDR = wmd;
                    if (wmd) m_mdr = bv;
                end
                run_access(dly, rd, 1, st, stb, a, wd, we);
                checks++;
                if (st !== dly + 1 || !stb || a !== m_mar || we !== (op == 3) || (op == 3 && wd !== m_mdr)) begin
                    errors++;
                    $display("FAIL rand_access[%0d]: stalls=%0d stable=%b addr=%h we=%b wdata=%h, want %0d 1 %h %b %h",
                             n, st, stb, a, we, wd, dly + 1, m_mar, op == 3, m_mdr);
                end
                if (op == 2) m_mdr = rd;
                checks++;
                if (mar !== m_mar || mdr !== m_mdr || enable !== 1 || mem_req !== 0) begin
                    errors++;
                    $display("FAIL rand_regs[%0d]: mar=%h mdr=%h en=%b req=%b, want %h %h 1 0",
                             n, mar, mdr, enable, mem_req, m_mar, m_mdr);
                end
            end
        end
    endtask

    task automatic test_reset_mid_access;
        bus_in = 16'h4242; ldMAR = 1; ldMDR = 1; selMDR = 1;
        step();
        clear_strobes();
        step();
        checks++;
        if (mem_req !== 1 || enable !== 0) begin
            errors++;
            $display("FAIL midreset pending: req=%b en=%b, want 1 0", mem_req, enable);
        end
        apply_reset();
        checks++;
        if (mem_req !== 0 || enable !== 1 || mar !== 0 || mdr !== 0 || mem_err !== 0) begin
            errors++;
            $display("FAIL midreset after: req=%b en=%b mar=%h mdr=%h err=%b, want 0 1 0000 0000 0",
                     mem_req, enable, mar, mdr, mem_err);
        end
    endtask

    task automatic test_violation;
        bit saw_req = 0;
        ldMDR = 1; selMDR = 1; memWE = 1;
        step();
        clear_strobes();
        for (int i = 0; i < 5; i++) begin
            saw_req |= mem_req;
            mem_ack = 1'($urandom);
            step();
        end
        mem_ack = 0;
        checks++;
        if (mem_err !== 1 || saw_req || enable !== 0) begin
            errors++;
            $display("FAIL violation: err=%b saw_req=%b en=%b, want 1 0 0", mem_err, saw_req, enable);
        end
        apply_reset();
        checks++;
        if (mem_err !== 0 || enable !== 1) begin
            errors++;
            $display("FAIL violation reset: err=%b en=%b, want 0 1", mem_err, enable);
        end
    endtask

    task automatic test_timeout;
        int waits = 0;
        ldMDR = 1; selMDR = 1;
        step();
        clear_strobes();
        for (int i = 0; i < 10 && mem_req; i++) begin
            waits++;
            step();
        end
        checks++;
        if (waits !== 4 || mem_err !== 1 || enable !== 0 || mem_req !== 0) begin
            errors++;
            $display("FAIL timeout: waits=%0d err=%b en=%b req=%b, want 4 1 0 0", waits, mem_err, enable, mem_req);
        end
        repeat (6) step();
        checks++;
        if (mem_err !== 1 || enable !== 0) begin
            errors++;
            $display("FAIL timeout sticky: err=%b en=%b, want 1 0", mem_err, enable);
        end
        apply_reset();
        checks++;
        if (mem_err !== 0 || enable !== 1 || mem_req !== 0 || mar !== 0 || mdr !== 0) begin
            errors++;
            $display("FAIL timeout reset: err=%b en=%b req=%b mar=%h mdr=%h, want 0 1 0 0000 0000",
                     mem_err, enable, mem_req, mar, mdr);
        end
    endtask

    initial begin
        step();
        apply_reset();
        test_reset();
        test_ldmar();
        test_read_zero_wait();
        test_write_delay();
        test_random();
        test_reset_mid_access();
        test_violation();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
